// File: rtl/writeback_stage_pkg.sv
// -----------------------------------------------------------------------------
// writeback_stage_pkg
// Shared CPU definitions for the writeback stage:
//   - wb_sel_e     : writeback source select (ALU / load / link / reserved)
//   - load_size_e  : load access width
//   - LINK_REG     : architectural link register index
//   - arb_state_e  : write-port arbiter priority states
//   - wb_entry_t   : the single held writeback entry
// Optional feature macro used by the stage: WB_RETIRE_CNT_EN (retire counter).
// -----------------------------------------------------------------------------
package writeback_stage_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_LINK = 2'b10,
    WB_SEL_RSVD = 2'b11   // behaves as ALU
  } wb_sel_e;

  typedef enum logic [1:0] {
    LS_BYTE     = 2'b00,
    LS_HALF     = 2'b01,
    LS_WORD     = 2'b10,
    LS_WORD_ALT = 2'b11   // also a full word
  } load_size_e;

  localparam logic [REG_AW-1:0] LINK_REG = 5'd31;

  typedef enum logic {
    PIPE_PRI = 1'b0,   // pipeline entry wins a contested cycle
    EXT_PRI  = 1'b1    // external unit wins a contested cycle
  } arb_state_e;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  // Priority alternates after every contested grant.
  function automatic arb_state_e arb_flip(input arb_state_e s);
    return (s == PIPE_PRI) ? EXT_PRI : PIPE_PRI;
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// -----------------------------------------------------------------------------
// writeback_stage_if
// Bundles every non-clock/reset signal of the writeback stage.
//   master : the surrounding pipeline / testbench (drives requests)
//   slave  : the writeback stage itself
// Groups: memory-stage handshake + result fields, external unit write port,
// register-file write port, forwarding bus, and (when WB_RETIRE_CNT_EN is
// defined) the Retire_Count output.
// -----------------------------------------------------------------------------
interface writeback_stage_if;

  // memory stage -> writeback
  logic        In_Valid;
  logic        In_Ready;
  logic        Flush;
  logic [1:0]  Wb_Sel;
  logic [31:0] Alu_Result;
  logic [31:0] Mem_Data;
  logic [31:0] Pc_Plus4;
  logic [4:0]  Dest_Addr;
  logic        Reg_Write;
  logic [1:0]  Load_Size;
  logic        Load_Signed;
  logic [1:0]  Byte_Offset;

  // multi-cycle unit write port
  logic        Ext_Req;
  logic [4:0]  Ext_Addr;
  logic [31:0] Ext_Data;
  logic        Ext_Ack;

  // register-file write port
  logic        Write_Enable;
  logic [4:0]  Write_Addr;
  logic [31:0] Data_in;

  // bypass of the held entry
  logic        Fwd_Valid;
  logic [4:0]  Fwd_Addr;
  logic [31:0] Fwd_Data;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] Retire_Count;
`endif

  modport slave (
    input  In_Valid, Flush, Wb_Sel, Alu_Result, Mem_Data, Pc_Plus4,
           Dest_Addr, Reg_Write, Load_Size, Load_Signed, Byte_Offset,
           Ext_Req, Ext_Addr, Ext_Data,
    output In_Ready, Ext_Ack, Write_Enable, Write_Addr, Data_in,
           Fwd_Valid, Fwd_Addr, Fwd_Data
`ifdef WB_RETIRE_CNT_EN
         , output Retire_Count
`endif
  );

  modport master (
    output In_Valid, Flush, Wb_Sel, Alu_Result, Mem_Data, Pc_Plus4,
           Dest_Addr, Reg_Write, Load_Size, Load_Signed, Byte_Offset,
           Ext_Req, Ext_Addr, Ext_Data,
    input  In_Ready, Ext_Ack, Write_Enable, Write_Addr, Data_in,
           Fwd_Valid, Fwd_Addr, Fwd_Data
`ifdef WB_RETIRE_CNT_EN
         , input Retire_Count
`endif
  );

endinterface

// File: rtl/writeback_stage_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational little-endian load extraction.
//   mem_data    in  32  raw aligned word from memory
//   load_size   in  2   byte / half / word
//   load_signed in  1   sign-extend (1) or zero-extend (0)
//   byte_offset in  2   byte lane; bit 0 is ignored for halfwords
//   load_data   out 32  extended result
// -----------------------------------------------------------------------------
module load_align
  import writeback_stage_pkg::*;
(
  input  logic [31:0] mem_data,
  input  logic [1:0]  load_size,
  input  logic        load_signed,
  input  logic [1:0]  byte_offset,
  output logic [31:0] load_data
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = mem_data[8*gi +: 8];
    end
  endgenerate

  assign byte_val = lane[byte_offset];
  assign half_val = byte_offset[1] ? mem_data[31:16] : mem_data[15:0];

  always_comb begin
    load_data = mem_data;
    case (load_size_e'(load_size))
      LS_BYTE: load_data = {{24{load_signed & byte_val[7]}}, byte_val};
      LS_HALF: load_data = {{16{load_signed & half_val[15]}}, half_val};
      default: load_data = mem_data;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
// Single-entry writeback buffer that shares the register-file write port with
// an external multi-cycle unit.
//   clk  in  1  rising-edge clock
//   rst  in  1  asynchronous active-low reset
//   bus  writeback_stage_if.slave : handshake, result fields, Ext port,
//        register-file write port, forwarding bus (see the interface file)
// Optional: define WB_RETIRE_CNT_EN to add the 32-bit Retire_Count output.
// The write port is arbitrated by a two-state priority FSM that alternates
// after every contested cycle; uncontested requesters are always granted.
// -----------------------------------------------------------------------------
module writeback_stage
  import writeback_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  writeback_stage_if.slave bus
);

  wb_entry_t  s_q, s_d;
  arb_state_e arb_q, arb_d;

  logic [31:0] load_data;
  logic [31:0] cap_data;
  logic [4:0]  cap_addr;
  logic        contest;
  logic        grant_s;
  logic        grant_ext;
  logic        in_ready;
  logic        capture;

  load_align u_load_align (
    .mem_data    (bus.Mem_Data),
    .load_size   (bus.Load_Size),
    .load_signed (bus.Load_Signed),
    .byte_offset (bus.Byte_Offset),
    .load_data   (load_data)
  );

  // Value and destination of an entry captured this cycle.
  always_comb begin
    cap_addr = bus.Dest_Addr;
    cap_data = bus.Alu_Result;
    case (wb_sel_e'(bus.Wb_Sel))
      WB_SEL_LOAD: cap_data = load_data;
      WB_SEL_LINK: begin
        cap_data = bus.Pc_Plus4;
        cap_addr = LINK_REG;
      end
      default: cap_data = bus.Alu_Result;
    endcase
  end

  // Arbitration. Grants are gated with rst so nothing is written or acked
  // while reset is asserted, even though Ext_Req may still be high.
  always_comb begin
    contest   = s_q.valid & bus.Ext_Req;
    grant_s   = rst & s_q.valid & (~bus.Ext_Req | (arb_q == PIPE_PRI));
    grant_ext = rst & bus.Ext_Req & (~s_q.valid | (arb_q == EXT_PRI));
    arb_d     = contest ? arb_flip(arb_q) : arb_q;
  end

  // A granted entry leaves this cycle, so a new one can enter behind it.
  assign in_ready = ~s_q.valid | grant_s;
  assign capture  = bus.In_Valid & in_ready & ~bus.Flush;

  always_comb begin
    s_d = s_q;
    if (grant_s | bus.Flush) begin
      s_d.valid = 1'b0;
    end
    if (capture) begin
      s_d.valid = 1'b1;
      s_d.we    = bus.Reg_Write;
      s_d.addr  = cap_addr;
      s_d.data  = cap_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q   <= '0;
      arb_q <= PIPE_PRI;
    end else begin
      s_q   <= s_d;
      arb_q <= arb_d;
    end
  end

  // Register-file write port: driven from whichever source holds the grant,
  // idle value zero. r0 writes still retire but never assert the enable.
  always_comb begin
    bus.Write_Enable = 1'b0;
    bus.Write_Addr   = '0;
    bus.Data_in      = '0;
    if (grant_s) begin
      bus.Write_Enable = s_q.we & (s_q.addr != 5'd0);
      bus.Write_Addr   = s_q.addr;
      bus.Data_in      = s_q.data;
    end else if (grant_ext) begin
      bus.Write_Enable = (bus.Ext_Addr != 5'd0);
      bus.Write_Addr   = bus.Ext_Addr;
      bus.Data_in      = bus.Ext_Data;
    end
  end

  assign bus.In_Ready  = in_ready;
  assign bus.Ext_Ack   = grant_ext;
  assign bus.Fwd_Valid = s_q.valid & s_q.we & (s_q.addr != 5'd0);
  assign bus.Fwd_Addr  = s_q.addr;
  assign bus.Fwd_Data  = s_q.data;

`ifdef WB_RETIRE_CNT_EN
  // Counts every retired pipeline entry; flushed entries never retire.
  logic [31:0] retire_cnt_q, retire_cnt_d;

  assign retire_cnt_d = retire_cnt_q + {31'd0, grant_s};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign bus.Retire_Count = retire_cnt_q;
`endif

endmodule
